// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache sitting between the
// fetch stage and the memory controller. Hits answer one cycle after
// acceptance; misses issue a single memory read. A flush during a miss
// abandons the response but still fills the line when the data arrives.
module icache #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        fetch_enable,
    input  logic [31:0] fetch_addr,
    input  logic        flush,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_instr
);

    localparam int IDXW = $clog2(LINES);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MISS  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_valid [LINES];
    logic [TAGW-1:0]   r_tag   [LINES];
    logic [31:0]       r_data  [LINES];

    logic              r_fetch_valid;
    logic [31:0]       r_fetch_instr;
    logic              r_mem_req;
    logic [31:0]       r_mem_addr;

    logic              w_fv_nxt;
    logic [31:0]       w_fi_nxt;
    logic              w_mreq_nxt;
    logic [31:0]       w_maddr_nxt;
    logic              w_fill;

    logic [IDXW-1:0]   w_req_idx;
    logic [TAGW-1:0]   w_req_tag;
    logic [IDXW-1:0]   w_fill_idx;
    logic [TAGW-1:0]   w_fill_tag;
    logic              w_hit;
    logic [1:0]        w_unused_addr_bits;

    // Byte-offset bits of the fetch address carry no information for a word cache.
    assign w_unused_addr_bits = fetch_addr[1:0];

    assign w_req_idx  = fetch_addr[IDXW+1:2];
    assign w_req_tag  = fetch_addr[31:IDXW+2];
    // The fill always targets the address that went out to memory.
    assign w_fill_idx = r_mem_addr[IDXW+1:2];
    assign w_fill_tag = r_mem_addr[31:IDXW+2];
    assign w_hit      = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);

    assign fetch_valid = r_fetch_valid;
    assign fetch_instr = r_fetch_instr;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;

    // Next-state and next-output decode for the fetch/miss controller.
    always_comb begin
        w_state_nxt = r_state;
        w_fv_nxt    = 1'b0;
        w_fi_nxt    = r_fetch_instr;
        w_mreq_nxt  = r_mem_req;
        w_maddr_nxt = r_mem_addr;
        w_fill      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The cycle after a response is blocked so a held request is not served twice.
                if (fetch_enable && !flush && !r_fetch_valid) begin
                    if (w_hit) begin
                        w_fv_nxt = 1'b1;
                        w_fi_nxt = r_data[w_req_idx];
                    end else begin
                        w_mreq_nxt  = 1'b1;
                        w_maddr_nxt = {fetch_addr[31:2], 2'b00};
                        w_state_nxt = ST_MISS;
                    end
                end else begin
                    w_mreq_nxt = 1'b0;
                end
            end
            ST_MISS: begin
                if (mem_valid) begin
                    w_fill      = 1'b1;
                    w_mreq_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                    if (!flush) begin
                        w_fv_nxt = 1'b1;
                        w_fi_nxt = mem_instr;
                    end else begin
                        w_fv_nxt = 1'b0;
                    end
                end else if (flush) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_MISS;
                end
            end
            ST_DRAIN: begin
                // Wait out the abandoned read; its data still refills the line.
                if (mem_valid) begin
                    w_fill      = 1'b1;
                    w_mreq_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_mreq_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; everything freezes while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_fetch_valid <= 1'b0;
            r_fetch_instr <= 32'h0000_0000;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= 32'h0000_0000;
        end else if (rdy) begin
            r_state       <= w_state_nxt;
            r_fetch_valid <= w_fv_nxt;
            r_fetch_instr <= w_fi_nxt;
            r_mem_req     <= w_mreq_nxt;
            r_mem_addr    <= w_maddr_nxt;
        end
    end

    // Line storage: only reset clears valid bits; fills write valid, tag and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (rdy && w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_tag[w_fill_idx]   <= w_fill_tag;
            r_data[w_fill_idx]  <= mem_instr;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (LINES=16). Inputs are driven
// 1 ns after each rising edge and outputs are sampled at the same point,
// so each tick() shows the result of the edge just taken.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        fetch_enable;
    logic [31:0] fetch_addr;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_instr;

    int checks   = 0;
    int failures = 0;

    icache #(.LINES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .fetch_enable (fetch_enable),
        .fetch_addr   (fetch_addr),
        .flush        (flush),
        .fetch_valid  (fetch_valid),
        .fetch_instr  (fetch_instr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_valid    (mem_valid),
        .mem_instr    (mem_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL rst_fv actual=%0h required=0", fetch_valid); end
        checks++; if (fetch_instr !== 32'h0) begin failures++; $display("FAIL rst_fi actual=%08h required=00000000", fetch_instr); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mreq actual=%0h required=0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_maddr actual=%08h required=00000000", mem_addr); end
    endtask

    task automatic test_cold_miss();
        fetch_enable = 1'b1; fetch_addr = 32'h0000_0104;
        tick();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL cold_mreq actual=%0h required=1", mem_req); end
        checks++; if (mem_addr !== 32'h0000_0104) begin failures++; $display("FAIL cold_maddr actual=%08h required=00000104", mem_addr); end
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL cold_fv0 actual=%0h required=0", fetch_valid); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0104 || fetch_valid !== 1'b0) begin
                failures++; $display("FAIL cold_hold cyc=%0d actual=%0h/%08h/%0h required=1/00000104/0", i, mem_req, mem_addr, fetch_valid); end
        end
        mem_valid = 1'b1; mem_instr = 32'h00A0_0093;
        tick();
        mem_valid = 1'b0; fetch_enable = 1'b0;
        checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL cold_fv actual=%0h required=1", fetch_valid); end
        checks++; if (fetch_instr !== 32'h00A0_0093) begin failures++; $display("FAIL cold_fi actual=%08h required=00a00093", fetch_instr); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL cold_mreq_drop actual=%0h required=0", mem_req); end
        tick();
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL cold_fv_pulse actual=%0h required=0", fetch_valid); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL cold_mreq_after actual=%0h required=0", mem_req); end
        checks++; if (fetch_instr !== 32'h00A0_0093) begin failures++; $display("FAIL cold_fi_hold actual=%08h required=00a00093", fetch_instr); end
    endtask

    task automatic test_hit();
        fetch_enable = 1'b1; fetch_addr = 32'h0000_0104;
        tick();
        fetch_enable = 1'b0;
        checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL hit_fv actual=%0h required=1", fetch_valid); end
        checks++; if (fetch_instr !== 32'h00A0_0093) begin failures++; $display("FAIL hit_fi actual=%08h required=00a00093", fetch_instr); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL hit_mreq actual=%0h required=0", mem_req); end
        tick();
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL hit_fv_pulse actual=%0h required=0", fetch_valid); end
    endtask

    task automatic test_conflict();
        fetch_enable = 1'b1; fetch_addr = 32'h0000_0144;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0144) begin failures++; $display("FAIL conf_miss actual=%0h/%08h required=1/00000144", mem_req, mem_addr); end
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL conf_fv0 actual=%0h required=0", fetch_valid); end
        mem_valid = 1'b1; mem_instr = 32'h1111_1111;
        tick();
        mem_valid = 1'b0; fetch_enable = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h1111_1111) begin failures++; $display("FAIL conf_resp actual=%0h/%08h required=1/11111111", fetch_valid, fetch_instr); end
        tick();
        fetch_enable = 1'b1; fetch_addr = 32'h0000_0104;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0104) begin failures++; $display("FAIL conf_remiss actual=%0h/%08h required=1/00000104", mem_req, mem_addr); end
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL conf_remiss_fv actual=%0h required=0", fetch_valid); end
        mem_valid = 1'b1; mem_instr = 32'h00A0_0093;
        tick();
        mem_valid = 1'b0; fetch_enable = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h00A0_0093) begin failures++; $display("FAIL conf_refill actual=%0h/%08h required=1/00a00093", fetch_valid, fetch_instr); end
        tick();
    endtask

    task automatic test_flush_miss();
        fetch_enable = 1'b1; fetch_addr = 32'h0000_0200;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0200) begin failures++; $display("FAIL fm_miss actual=%0h/%08h required=1/00000200", mem_req, mem_addr); end
        tick();
        flush = 1'b1; fetch_enable = 1'b0;
        tick();
        flush = 1'b0;
        checks++; if (mem_req !== 1'b1 || fetch_valid !== 1'b0) begin failures++; $display("FAIL fm_flush actual=%0h/%0h required=1/0", mem_req, fetch_valid); end
        tick(); tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0200) begin failures++; $display("FAIL fm_drain_hold actual=%0h/%08h required=1/00000200", mem_req, mem_addr); end
        mem_valid = 1'b1; mem_instr = 32'h2222_2222;
        tick();
        mem_valid = 1'b0;
        checks++; if (fetch_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL fm_drain_done actual=%0h/%0h required=0/0", fetch_valid, mem_req); end
        checks++; if (fetch_instr !== 32'h00A0_0093) begin failures++; $display("FAIL fm_fi_hold actual=%08h required=00a00093", fetch_instr); end
        tick();
        checks++; if (fetch_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL fm_quiet actual=%0h/%0h required=0/0", fetch_valid, mem_req); end
        fetch_enable = 1'b1; fetch_addr = 32'h0000_0200;
        tick();
        fetch_enable = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h2222_2222 || mem_req !== 1'b0) begin
            failures++; $display("FAIL fm_hit actual=%0h/%08h/%0h required=1/22222222/0", fetch_valid, fetch_instr, mem_req); end
        tick();
    endtask

    task automatic test_flush_same_cycle();
        fetch_enable = 1'b1; fetch_addr = 32'h0000_0300;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0300) begin failures++; $display("FAIL fs_miss actual=%0h/%08h required=1/00000300", mem_req, mem_addr); end
        tick();
        flush = 1'b1; mem_valid = 1'b1; mem_instr = 32'h3333_3333; fetch_enable = 1'b0;
        tick();
        flush = 1'b0; mem_valid = 1'b0;
        checks++; if (fetch_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL fs_resp actual=%0h/%0h required=0/0", fetch_valid, mem_req); end
        checks++; if (fetch_instr !== 32'h2222_2222) begin failures++; $display("FAIL fs_fi_hold actual=%08h required=22222222", fetch_instr); end
        fetch_enable = 1'b1; fetch_addr = 32'h0000_0300;
        tick();
        fetch_enable = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h3333_3333 || mem_req !== 1'b0) begin
            failures++; $display("FAIL fs_hit actual=%0h/%08h/%0h required=1/33333333/0", fetch_valid, fetch_instr, mem_req); end
        tick();
    endtask

    task automatic test_flush_idle();
        fetch_enable = 1'b1; fetch_addr = 32'h0000_0104; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (fetch_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL fi_block actual=%0h/%0h required=0/0", fetch_valid, mem_req); end
        tick();
        fetch_enable = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h00A0_0093) begin failures++; $display("FAIL fi_keep actual=%0h/%08h required=1/00a00093", fetch_valid, fetch_instr); end
        tick();
    endtask

    task automatic test_rdy_stall();
        fetch_enable = 1'b1; fetch_addr = 32'h0000_0400;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0400) begin failures++; $display("FAIL rs_miss actual=%0h/%08h required=1/00000400", mem_req, mem_addr); end
        rdy = 1'b0; mem_valid = 1'b1; mem_instr = 32'h4444_4444;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0400 || fetch_valid !== 1'b0) begin
                failures++; $display("FAIL rs_miss_frozen cyc=%0d actual=%0h/%08h/%0h required=1/00000400/0", i, mem_req, mem_addr, fetch_valid); end
        end
        rdy = 1'b1;
        tick();
        mem_valid = 1'b0; fetch_enable = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h4444_4444 || mem_req !== 1'b0) begin
            failures++; $display("FAIL rs_resume actual=%0h/%08h/%0h required=1/44444444/0", fetch_valid, fetch_instr, mem_req); end
        tick();
        fetch_enable = 1'b1;
        tick();
        rdy = 1'b0; fetch_enable = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h4444_4444) begin failures++; $display("FAIL rs_hit actual=%0h/%08h required=1/44444444", fetch_valid, fetch_instr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h4444_4444 || mem_req !== 1'b0) begin
                failures++; $display("FAIL rs_hit_frozen cyc=%0d actual=%0h/%08h/%0h required=1/44444444/0", i, fetch_valid, fetch_instr, mem_req); end
        end
        rdy = 1'b1;
        tick();
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL rs_hit_end actual=%0h required=0", fetch_valid); end
    endtask

    task automatic test_reset_priority();
        fetch_enable = 1'b1; fetch_addr = 32'h0000_0500;
        tick();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rp_miss actual=%0h required=1", mem_req); end
        rst = 1'b1; rdy = 1'b0; fetch_enable = 1'b0;
        tick();
        rst = 1'b0; rdy = 1'b1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || fetch_valid !== 1'b0 || fetch_instr !== 32'h0) begin
            failures++; $display("FAIL rp_reset actual=%0h/%08h/%0h/%08h required=0/00000000/0/00000000", mem_req, mem_addr, fetch_valid, fetch_instr); end
        mem_valid = 1'b1; mem_instr = 32'h5555_5555;
        tick();
        mem_valid = 1'b0;
        checks++; if (fetch_valid !== 1'b0 || mem_req !== 1'b0 || fetch_instr !== 32'h0) begin
            failures++; $display("FAIL rp_stray actual=%0h/%0h/%08h required=0/0/00000000", fetch_valid, mem_req, fetch_instr); end
        fetch_enable = 1'b1; fetch_addr = 32'h0000_0104;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0104 || fetch_valid !== 1'b0) begin
            failures++; $display("FAIL rp_cold actual=%0h/%08h/%0h required=1/00000104/0", mem_req, mem_addr, fetch_valid); end
        mem_valid = 1'b1; mem_instr = 32'h00A0_0093;
        tick();
        mem_valid = 1'b0; fetch_enable = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h00A0_0093) begin failures++; $display("FAIL rp_fill actual=%0h/%08h required=1/00a00093", fetch_valid, fetch_instr); end
        tick();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; fetch_enable = 1'b0; fetch_addr = 32'h0;
        flush = 1'b0; mem_valid = 1'b0; mem_instr = 32'h0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_miss();
        test_flush_same_cycle();
        test_flush_idle();
        test_rdy_stall();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
